// File: rtl/fd_branch_stage.sv
// Fetch/decode pipeline register with branch resolution (B, BR) and HLT handling.
// Optional BRANCH_STATS_EN adds saturating taken/resolved branch counters.
module fd_branch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] F_out,
  input  logic        stall,
  input  logic [2:0]  flags,
  input  logic        flag_wait,
  input  logic [15:0] rs_data,
  output logic [15:0] D_pc_plus_2,
  output logic [15:0] D_instruction,
  output logic        D_valid,
  output logic        flush,
  output logic [15:0] branch_target,
  output logic        branch_stall,
  output logic        halt
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_count,
  output logic [15:0] resolved_count
`endif
);

  localparam int unsigned W = 16;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  typedef enum logic [1:0] {RUN, WAIT, HALTED} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, instr_q;
  logic           valid_q;
  logic           load_en, bubble, resolved;

  logic [3:0]     opcode;
  logic [2:0]     cond;
  logic           is_b, is_br, is_hlt, is_branch, cond_ok;
  logic           flag_z, flag_v, flag_n;
  logic [W-1:0]   b_offset, target;

  assign opcode    = instr_q[15:12];
  assign cond      = instr_q[11:9];
  assign is_b      = valid_q && (opcode == OP_B);
  assign is_br     = valid_q && (opcode == OP_BR);
  assign is_hlt    = valid_q && (opcode == OP_HLT);
  assign is_branch = is_b || is_br;
  assign {flag_z, flag_v, flag_n} = flags;

  // Sign-extended 9-bit word offset scaled to bytes.
  assign b_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
  assign target   = is_b ? W'(pc_q + b_offset) : rs_data;

  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      3'b000:  cond_ok = !flag_z;
      3'b001:  cond_ok = flag_z;
      3'b010:  cond_ok = !flag_z && !flag_n;
      3'b011:  cond_ok = flag_n;
      3'b100:  cond_ok = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_ok = flag_n || flag_z;
      3'b110:  cond_ok = flag_v;
      default: cond_ok = 1'b1;
    endcase
  end

  // Next state, resolution outputs and register update enables.
  always_comb begin
    state_d       = state_q;
    branch_stall  = 1'b0;
    flush         = 1'b0;
    branch_target = '0;
    load_en       = 1'b0;
    bubble        = 1'b0;
    resolved      = 1'b0;
    case (state_q)
      RUN, WAIT: begin
        if (is_branch && (cond != COND_ALWAYS) && flag_wait) begin
          branch_stall = 1'b1;
          state_d      = WAIT;
        end else begin
          state_d  = RUN;
          resolved = is_branch && !stall;
          if (is_branch && cond_ok && !stall) begin
            flush         = 1'b1;
            branch_target = target;
            bubble        = 1'b1;
          end else if (is_hlt && !stall) begin
            state_d = HALTED;
          end else if (!stall) begin
            load_en = 1'b1;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bubble) begin
        pc_q    <= '0;
        instr_q <= '0;
        valid_q <= 1'b0;
      end else if (load_en) begin
        pc_q    <= F_out[31:16];
        instr_q <= F_out[15:0];
        valid_q <= 1'b1;
      end
    end
  end

  assign D_pc_plus_2   = pc_q;
  assign D_instruction = instr_q;
  assign D_valid       = valid_q;
  assign halt          = (state_q == HALTED);

`ifdef BRANCH_STATS_EN
  logic [W-1:0] taken_q, resolved_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q    <= '0;
      resolved_q <= '0;
    end else begin
      if (flush && (taken_q != '1))
        taken_q <= W'(taken_q + W'(1));
      if (resolved && (resolved_q != '1))
        resolved_q <= W'(resolved_q + W'(1));
    end
  end

  assign taken_count    = taken_q;
  assign resolved_count = resolved_q;
`endif

endmodule

// File: tb/tb_fd_branch_stage.sv
// Randomized self-checking bench for fd_branch_stage against a spec-level reference model.
module tb_fd_branch_stage;

  logic        clk, rst_n;
  logic [31:0] f_out;
  logic        stall, flag_wait;
  logic [2:0]  flags;
  logic [15:0] rs_data;
  logic [15:0] d_pc, d_ins, branch_target;
  logic        d_valid, flush, branch_stall, halt;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count, resolved_count;
`endif

  fd_branch_stage dut (
    .clk(clk), .rst_n(rst_n), .F_out(f_out), .stall(stall), .flags(flags),
    .flag_wait(flag_wait), .rs_data(rs_data), .D_pc_plus_2(d_pc),
    .D_instruction(d_ins), .D_valid(d_valid), .flush(flush),
    .branch_target(branch_target), .branch_stall(branch_stall), .halt(halt)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count), .resolved_count(resolved_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what D holds, and whether HLT has taken effect.
  logic [15:0] m_pc, m_ins;
  logic        m_val, m_halt;
  int          m_taken, m_resolved;
  logic        e_flush, e_bstall, e_res;
  logic [15:0] e_tgt;

  function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] fl);
    logic z, v, n;
    {z, v, n} = fl;
    case (c)
      3'd0: return z == 0;
      3'd1: return z == 1;
      3'd2: return (z == 0) && (n == 0);
      3'd3: return n == 1;
      3'd4: return (z == 1) || ((z == 0) && (n == 0));
      3'd5: return (n == 1) || (z == 1);
      3'd6: return v == 1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_eval();
    logic [3:0] op;
    logic [2:0] c;
    logic [8:0] imm;
    logic       br;
    int         off;
    op  = m_ins[15:12];
    c   = m_ins[11:9];
    imm = m_ins[8:0];
    br  = m_val && !m_halt && (op == 4'hC || op == 4'hD);
    e_bstall = br && (c != 3'd7) && flag_wait;
    e_res    = br && !e_bstall;
    e_flush  = e_res && !stall && cond_holds(c, flags);
    off      = int'(imm) - (imm[8] ? 512 : 0);
    e_tgt    = !e_flush ? 16'h0000 :
               (op == 4'hC) ? 16'(int'(m_pc) + 2 * off) : rs_data;
  endtask

  task automatic model_next();
    if (e_flush) m_taken = (m_taken < 65535) ? m_taken + 1 : m_taken;
    if (e_res && !stall) m_resolved = (m_resolved < 65535) ? m_resolved + 1 : m_resolved;
    if (m_halt || stall || e_bstall) return;
    if (e_flush) begin
      m_pc = 0; m_ins = 0; m_val = 0;
    end else if (m_val && m_ins[15:12] == 4'hF) begin
      m_halt = 1;
    end else begin
      m_pc = f_out[31:16]; m_ins = f_out[15:0]; m_val = 1;
    end
  endtask

  task automatic cmp_all();
    check16("d_pc", d_pc, m_pc);
    check16("d_ins", d_ins, m_ins);
    check16("d_valid", 16'(d_valid), 16'(m_val));
    check16("halt", 16'(halt), 16'(m_halt));
    check16("flush", 16'(flush), 16'(e_flush));
    check16("bstall", 16'(branch_stall), 16'(e_bstall));
    check16("target", branch_target, e_tgt);
`ifdef BRANCH_STATS_EN
    check16("taken_cnt", taken_count, 16'(m_taken));
    check16("resolved_cnt", resolved_count, 16'(m_resolved));
`endif
  endtask

  // Drive inputs mid-cycle, then compare against the model before the edge.
  task automatic apply(input logic [31:0] f, input logic st, input logic [2:0] fl,
                       input logic fw, input logic [15:0] rs);
    f_out = f; stall = st; flags = fl; flag_wait = fw; rs_data = rs;
    #1;
    model_eval();
    cmp_all();
  endtask

  task automatic adv();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_pc = 0; m_ins = 0; m_val = 0; m_halt = 0; m_taken = 0; m_resolved = 0;
    check16("rst_pc", d_pc, 16'h0000);
    check16("rst_ins", d_ins, 16'h0000);
    check16("rst_valid", 16'(d_valid), 16'h0000);
    check16("rst_flush", 16'(flush), 16'h0000);
    check16("rst_bstall", 16'(branch_stall), 16'h0000);
    check16("rst_halt", 16'(halt), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [3:0] op;
    r  = $urandom_range(0, 39);
    op = (r < 12) ? 4'hC : (r < 22) ? 4'hD : (r == 22) ? 4'hF : 4'($urandom_range(0, 11));
    return {op, 12'($urandom)};
  endfunction

  initial begin
    rst_n = 1'b0; f_out = '0; stall = 0; flags = '0; flag_wait = 0; rs_data = '0;
    do_reset();

    // Plain load after reset.
    apply(32'h0002_1123, 0, 3'b000, 0, 16'h0);
    adv();
    check16("load_pc", d_pc, 16'h0002);
    check16("load_ins", d_ins, 16'h1123);
    check16("load_valid", 16'(d_valid), 16'h0001);

    // Unconditional B with negative offset.
    apply(32'h0010_CFFE, 0, 3'b000, 0, 16'h0);
    adv();
    apply(32'h0012_1111, 0, 3'b000, 0, 16'h0);
    check16("b_flush", 16'(flush), 16'h0001);
    check16("b_target", branch_target, 16'h000C);
    adv();
    check16("b_bubble", 16'(d_valid), 16'h0000);

    // B cond=001 waits on flags for three cycles, then resolves taken.
    apply(32'h0020_C204, 0, 3'b000, 0, 16'h0);
    adv();
    for (int k = 0; k < 3; k++) begin
      apply(32'h0022_2222, 0, 3'b000, 1, 16'h0);
      check16("wait_bstall", 16'(branch_stall), 16'h0001);
      check16("wait_flush", 16'(flush), 16'h0000);
      adv();
      check16("wait_hold", d_ins, 16'hC204);
    end
    apply(32'h0022_2222, 0, 3'b100, 0, 16'h0);
    check16("wait_resolve", 16'(flush), 16'h0001);
    check16("wait_target", branch_target, 16'h0028);
    adv();

    // BR held by stall, then taken once stall drops.
    apply(32'h0030_DE00, 0, 3'b000, 0, 16'h0);
    adv();
    apply(32'h0032_3333, 1, 3'b000, 0, 16'h0400);
    check16("br_stall_flush", 16'(flush), 16'h0000);
    adv();
    check16("br_hold", d_ins, 16'hDE00);
    apply(32'h0032_3333, 0, 3'b000, 0, 16'h0400);
    check16("br_flush", 16'(flush), 16'h0001);
    check16("br_target", branch_target, 16'h0400);
    adv();

    // HLT shadowed by a taken branch is squashed; an unshadowed one halts.
    apply(32'h0040_CFFE, 0, 3'b000, 0, 16'h0);
    adv();
    apply(32'h0042_F000, 0, 3'b000, 0, 16'h0);
    adv();
    check16("squash_halt", 16'(halt), 16'h0000);
    check16("squash_valid", 16'(d_valid), 16'h0000);
    apply(32'h0044_1000, 0, 3'b000, 0, 16'h0);
    adv();
    apply(32'h0050_F000, 0, 3'b000, 0, 16'h0);
    adv();
    apply(32'h0052_1234, 0, 3'b000, 0, 16'h0);
    adv();
    check16("halt_set", 16'(halt), 16'h0001);
    for (int k = 0; k < 5; k++) begin
      apply($urandom, 1'($urandom), 3'($urandom), 1'($urandom), 16'($urandom));
      adv();
    end
    check16("halt_frozen_ins", d_ins, 16'hF000);
    check16("halt_frozen_pc", d_pc, 16'h0050);
    check16("halt_sticky", 16'(halt), 16'h0001);

    // Reset while a branch waits on flags.
    do_reset();
    apply(32'h0060_C204, 0, 3'b000, 0, 16'h0);
    adv();
    apply(32'h0062_4444, 0, 3'b000, 1, 16'h0);
    adv();
    do_reset();
    apply(32'h0070_5555, 0, 3'b000, 0, 16'h0);
    check16("post_rst_bstall", 16'(branch_stall), 16'h0000);
    adv();
    check16("post_rst_ins", d_ins, 16'h5555);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_halt && $urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        apply({16'($urandom), rand_instr()}, ($urandom_range(0, 4) == 0),
              3'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom));
        adv();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
